// File: rtl/put_in_order_fifo.sv
// put_in_order_fifo
//   Merges n_inputs independent upstream channels into one output stream in strict round-robin
//   channel order 0,1,...,n_inputs-1,0,...
//   Each channel has a private FIFO, so a channel may run up to `depth` items ahead of the output.
//   Valid/ready handshakes on both sides give full backpressure.
//   There is no combinational path from the upstream inputs to the downstream outputs.
//
// Optional feature macro: PUT_IN_ORDER_FIFO_ERR_EN
//   When defined, it adds the up_errs port.
//   up_errs[i] is a sticky flag. It is set after a push attempt on a full channel i.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active low
//   up_vlds    per-channel item valid
//   up_rdys    per-channel ready (channel FIFO not full)
//   up_data    per-channel item data
//   down_vld   output item valid (FIFO[cur] not empty)
//   down_rdy   downstream accepts the item
//   down_data  head of FIFO[cur]
//   down_chan  channel index of the current output item (cur)
//   up_errs    sticky overflow flags (PUT_IN_ORDER_FIFO_ERR_EN only)

module put_in_order_fifo #(
    parameter int unsigned width    = 16,
    parameter int unsigned n_inputs = 4,
    parameter int unsigned depth    = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [n_inputs-1:0]                up_vlds,
    output logic [n_inputs-1:0]                up_rdys,
    input  logic [n_inputs-1:0][width-1:0]     up_data,
    output logic                               down_vld,
    input  logic                               down_rdy,
    output logic [width-1:0]                   down_data,
    output logic [$clog2(n_inputs)-1:0]        down_chan
`ifdef PUT_IN_ORDER_FIFO_ERR_EN
    ,
    output logic [n_inputs-1:0]                up_errs
`endif
);

    localparam int unsigned CW = $clog2(n_inputs);
    localparam int unsigned PW = $clog2(depth);
    localparam int unsigned NW = $clog2(depth + 1);

    // Storage is deliberately not reset; only pointers and counts are.
    logic [width-1:0] mem_q [n_inputs][depth];

    logic [PW-1:0] wr_ptr_q [n_inputs];
    logic [PW-1:0] wr_ptr_d [n_inputs];
    logic [PW-1:0] rd_ptr_q [n_inputs];
    logic [PW-1:0] rd_ptr_d [n_inputs];
    logic [NW-1:0] cnt_q    [n_inputs];
    logic [NW-1:0] cnt_d    [n_inputs];
    logic [CW-1:0] cur_q, cur_d;

    logic [n_inputs-1:0] push;
    logic [n_inputs-1:0] pop;

    always_comb begin
        up_rdys   = '0;
        push      = '0;
        pop       = '0;
        cur_d     = cur_q;
        down_chan = cur_q;
        down_vld  = (cnt_q[cur_q] != '0);
        down_data = mem_q[cur_q][rd_ptr_q[cur_q]];

        if (down_vld && down_rdy) begin
            cur_d = (cur_q == CW'(n_inputs - 1)) ? '0 : cur_q + CW'(1);
        end

        for (int i = 0; i < n_inputs; i++) begin
            // Ready depends on the count only, so a full FIFO refuses even when popped this cycle.
            up_rdys[i]  = (cnt_q[i] != NW'(depth));
            push[i]     = up_vlds[i] & up_rdys[i];
            pop[i]      = down_vld & down_rdy & (cur_q == CW'(i));
            wr_ptr_d[i] = push[i] ? wr_ptr_q[i] + PW'(1) : wr_ptr_q[i];
            rd_ptr_d[i] = pop[i]  ? rd_ptr_q[i] + PW'(1) : rd_ptr_q[i];
            unique case ({push[i], pop[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + NW'(1);
                2'b01:   cnt_d[i] = cnt_q[i] - NW'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_q <= '0;
            for (int i = 0; i < n_inputs; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            cur_q <= cur_d;
            for (int i = 0; i < n_inputs; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < n_inputs; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= up_data[i];
            end
        end
    end

`ifdef PUT_IN_ORDER_FIFO_ERR_EN
    logic [n_inputs-1:0] err_q, err_d;

    always_comb begin
        err_d   = err_q | (up_vlds & ~up_rdys);
        up_errs = err_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_put_in_order_fifo.sv
// Testbench for put_in_order_fifo (width=16, n_inputs=4, depth=4).
// Table-driven vectors cover in-order fill, reverse arrival and run-ahead.
// Hand sequences cover mid-run reset, backpressure, and full + same-cycle pop.

module tb_put_in_order_fifo;

    localparam int unsigned W = 16;
    localparam int unsigned N = 4;
    localparam int unsigned D = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          up_vlds;
    logic [N-1:0]          up_rdys;
    logic [N-1:0][W-1:0]   up_data;
    logic                  down_vld;
    logic                  down_rdy;
    logic [W-1:0]          down_data;
    logic [1:0]            down_chan;
`ifdef PUT_IN_ORDER_FIFO_ERR_EN
    logic [N-1:0]          up_errs;
`endif

    put_in_order_fifo #(
        .width    (W),
        .n_inputs (N),
        .depth    (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .up_vlds   (up_vlds),
        .up_rdys   (up_rdys),
        .up_data   (up_data),
        .down_vld  (down_vld),
        .down_rdy  (down_rdy),
        .down_data (down_data),
        .down_chan (down_chan)
`ifdef PUT_IN_ORDER_FIFO_ERR_EN
        ,
        .up_errs   (up_errs)
`endif
    );

    always #5 clk = ~clk;

    // Inputs are applied for one cycle.
    // Expected outputs are those seen during that same cycle, before its rising edge.
    typedef struct {
        logic [N-1:0] vlds;
        logic [W-1:0] din;
        logic         rdy;
        logic         evld;
        logic [1:0]   echan;
        logic [W-1:0] edata;
        logic [N-1:0] erdys;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic add(input logic [N-1:0] vlds, input logic [W-1:0] din, input logic rdy,
                       input logic evld, input logic [1:0] echan, input logic [W-1:0] edata,
                       input logic [N-1:0] erdys);
        vec_t v;
        v.vlds = vlds; v.din = din; v.rdy = rdy;
        v.evld = evld; v.echan = echan; v.edata = edata; v.erdys = erdys;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] vlds, input logic [W-1:0] din, input logic rdy);
        @(negedge clk);
        rst      = 1'b1;
        up_vlds  = vlds;
        for (int c = 0; c < N; c++) up_data[c] = din;
        down_rdy = rdy;
        #1;
    endtask

    // One reset edge; returns #1 after the following negedge with rst released.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; up_vlds = '0; down_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    initial begin
        int           got;
        logic         held;
        logic [W-1:0] prev_data;
        logic [1:0]   prev_chan;
        logic [W-1:0] exp_d;
        logic [3:0]   pat;

        rst = 1'b0; up_vlds = '0; up_data = '0; down_rdy = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_vld",  {31'b0, down_vld}, 32'd0);
        check("reset_chan", {30'b0, down_chan}, 32'd0);
        check("reset_rdys", {28'b0, up_rdys}, 32'hF);
`ifdef PUT_IN_ORDER_FIFO_ERR_EN
        check("reset_errs", {28'b0, up_errs}, 32'h0);
`endif

        // In-order fill, one per cycle, down_rdy=1
        add(4'b0001, 16'h00A0, 1, 0, 0, 16'h0000, 4'hF);
        add(4'b0010, 16'h00B1, 1, 1, 0, 16'h00A0, 4'hF);
        add(4'b0100, 16'h00C2, 1, 1, 1, 16'h00B1, 4'hF);
        add(4'b1000, 16'h00D3, 1, 1, 2, 16'h00C2, 4'hF);
        add(4'b0000, 16'h0000, 1, 1, 3, 16'h00D3, 4'hF);
        add(4'b0000, 16'h0000, 1, 0, 0, 16'h0000, 4'hF);
        // Reverse arrival
        add(4'b1000, 16'h0033, 1, 0, 0, 16'h0000, 4'hF);
        add(4'b0100, 16'h0022, 1, 0, 0, 16'h0000, 4'hF);
        add(4'b0010, 16'h0011, 1, 0, 0, 16'h0000, 4'hF);
        add(4'b0001, 16'h0000, 1, 0, 0, 16'h0000, 4'hF);
        add(4'b0000, 16'h0000, 1, 1, 0, 16'h0000, 4'hF);
        add(4'b0000, 16'h0000, 1, 1, 1, 16'h0011, 4'hF);
        add(4'b0000, 16'h0000, 1, 1, 2, 16'h0022, 4'hF);
        add(4'b0000, 16'h0000, 1, 1, 3, 16'h0033, 4'hF);
        add(4'b0000, 16'h0000, 1, 0, 0, 16'h0000, 4'hF);
        // Run-ahead on ch1 while ch0 is silent
        add(4'b0010, 16'h0100, 1, 0, 0, 16'h0000, 4'hF);
        add(4'b0010, 16'h0101, 1, 0, 0, 16'h0000, 4'hF);
        add(4'b0010, 16'h0102, 1, 0, 0, 16'h0000, 4'hF);
        add(4'b0010, 16'h0103, 1, 0, 0, 16'h0000, 4'hF);
        add(4'b0011, 16'h00AA, 1, 0, 0, 16'h0000, 4'b1101);
        add(4'b0000, 16'h0000, 1, 1, 0, 16'h00AA, 4'b1101);
        add(4'b0000, 16'h0000, 1, 1, 1, 16'h0100, 4'b1101);
        add(4'b0000, 16'h0000, 1, 0, 2, 16'h0000, 4'hF);

        foreach (vecs[k]) begin
            drive(vecs[k].vlds, vecs[k].din, vecs[k].rdy);
            check($sformatf("v%0d_vld", k),  {31'b0, down_vld}, {31'b0, vecs[k].evld});
            check($sformatf("v%0d_chan", k), {30'b0, down_chan}, {30'b0, vecs[k].echan});
            check($sformatf("v%0d_rdys", k), {28'b0, up_rdys}, {28'b0, vecs[k].erdys});
            if (vecs[k].evld)
                check($sformatf("v%0d_data", k), {16'b0, down_data}, {16'b0, vecs[k].edata});
        end

        // Mid-run reset with 3 items still queued on ch1
        do_reset();
        check("mreset_vld",  {31'b0, down_vld}, 32'd0);
        check("mreset_chan", {30'b0, down_chan}, 32'd0);
        check("mreset_rdys", {28'b0, up_rdys}, 32'hF);
`ifdef PUT_IN_ORDER_FIFO_ERR_EN
        check("mreset_errs", {28'b0, up_errs}, 32'h0);
`endif
        up_vlds = 4'b0001; up_data[0] = 16'h00C0; down_rdy = 1'b1;
        drive(4'b0000, 16'h0000, 1'b1);
        check("mreset_first_vld",  {31'b0, down_vld}, 32'd1);
        check("mreset_first_data", {16'b0, down_data}, 32'h00C0);
        drive(4'b0000, 16'h0000, 1'b1);
        check("mreset_ch1_empty", {31'b0, down_vld}, 32'd0);
        check("mreset_ch1_chan",  {30'b0, down_chan}, 32'd1);

        // Backpressure: load all FIFOs full, drain 16 items with down_rdy 1,0,0,1
        do_reset();
        for (int r = 0; r < 4; r++) begin
            if (r != 0) begin
                @(negedge clk);
            end
            up_vlds = 4'hF; down_rdy = 1'b0;
            for (int c = 0; c < N; c++) up_data[c] = 16'(16'h0A00 + c * 16 + r);
        end
        drive(4'b0000, 16'h0000, 1'b0);
        check("bp_all_full", {28'b0, up_rdys}, 32'h0);
        pat = 4'b1001;
        got = 0;
        held = 1'b0;
        prev_data = '0;
        prev_chan = '0;
        for (int cyc = 0; cyc < 64 && got < 16; cyc++) begin
            drive(4'b0000, 16'h0000, pat[3 - (cyc % 4)]);
            if (held) begin
                check("bp_hold_vld",  {31'b0, down_vld}, 32'd1);
                check("bp_hold_data", {16'b0, down_data}, {16'b0, prev_data});
                check("bp_hold_chan", {30'b0, down_chan}, {30'b0, prev_chan});
            end
            if (down_vld && down_rdy) begin
                exp_d = 16'(16'h0A00 + (got % 4) * 16 + got / 4);
                check($sformatf("bp_item%0d_chan", got), {30'b0, down_chan}, 32'(got % 4));
                check($sformatf("bp_item%0d_data", got), {16'b0, down_data}, {16'b0, exp_d});
                got++;
            end
            held      = down_vld && !down_rdy;
            prev_data = down_data;
            prev_chan = down_chan;
        end
        check("bp_count", 32'(got), 32'd16);
        drive(4'b0000, 16'h0000, 1'b1);
        check("bp_drained", {31'b0, down_vld}, 32'd0);

        // Full FIFO[cur] + same-cycle pop: push refused, count ends at depth-1
        do_reset();
        for (int r = 0; r < 4; r++) begin
            if (r != 0) begin
                @(negedge clk);
            end
            up_vlds = 4'b0001; down_rdy = 1'b0; up_data[0] = 16'(16'h0050 + r);
        end
        drive(4'b0001, 16'h00EE, 1'b1);
        check("fullpop_rdy0", {31'b0, up_rdys[0]}, 32'd0);
        check("fullpop_vld",  {31'b0, down_vld}, 32'd1);
        check("fullpop_data", {16'b0, down_data}, 32'h0050);
        drive(4'b0000, 16'h0000, 1'b0);
        check("fullpop_after_rdy0", {31'b0, up_rdys[0]}, 32'd1);
        check("fullpop_after_chan", {30'b0, down_chan}, 32'd1);
`ifdef PUT_IN_ORDER_FIFO_ERR_EN
        check("fullpop_err0", {28'b0, up_errs}, 32'h1);
`endif
        drive(4'b0001, 16'h0054, 1'b0);
        drive(4'b0000, 16'h0000, 1'b0);
        check("fullpop_refill_rdy0", {31'b0, up_rdys[0]}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
